fault_campaign_ctrl: RTL and testbench

Synthesizable fault-injection campaign sequencer for the hydra SoC. It runs NEXP experiments back-to-back. Each experiment resets the DUT, waits for the software start flag, and with programmable probability injects one fault into one of N_TARGETS registers after an LFSR-drawn delay. It then waits for the done flag or a timeout, and records the outcome in counters. It sits beside the primary CPU, driving its reset and register/PC fault ports.

---
 rtl/fault_campaign_ctrl_if.sv | 42 ++++
 rtl/fault_campaign_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_fault_campaign_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fault_campaign_ctrl_if.sv
// Campaign sequencer bundle: control inputs, DUT reset/fault
// strobe, per-experiment result and campaign counters.
interface fault_campaign_ctrl_if #(
   parameter int N_TARGETS = 7,
   parameter int DATA_W    = 32
);
   localparam int TGT_W = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;

   logic              start;
   logic [1:0]        fault_mode;
   logic              run_begin;
   logic              run_done;
   logic              dut_rstn;
   logic              fault_valid;
   logic [1:0]        fault_op;
   logic [TGT_W-1:0]  fault_target;
   logic [DATA_W-1:0] fault_mask;
   logic              result_valid;
   logic [1:0]        result_code;
   logic [15:0]       exp_count;
   logic [15:0]       cnt_inj;
   logic [15:0]       cnt_done_inj;
   logic [15:0]       cnt_timeout;
   logic              busy;
   logic              campaign_done;

   modport master (
      input  start, fault_mode, run_begin, run_done,
      output dut_rstn, fault_valid, fault_op, fault_target,
      output fault_mask, result_valid, result_code,
      output exp_count, cnt_inj, cnt_done_inj, cnt_timeout,
      output busy, campaign_done
   );

   modport slave (
      output start, fault_mode, run_begin, run_done,
      input  dut_rstn, fault_valid, fault_op, fault_target,
      input  fault_mask, result_valid, result_code,
      input  exp_count, cnt_inj, cnt_done_inj, cnt_timeout,
      input  busy, campaign_done
   );
endinterface

// File: rtl/fault_campaign_ctrl.sv
// Fault-injection campaign sequencer: resets the CPU, draws an
// injection from an LFSR, fires it, and tallies each outcome.
module fault_campaign_ctrl #(
   parameter int          N_TARGETS    = 7,
   parameter int          DATA_W       = 32,
   parameter int          NEXP         = 10,
   parameter int          FR_THRESH    = 179,
   parameter int          DELAY_MIN    = 900,
   parameter int          DELAY_SPAN_W = 11,
   parameter logic [31:0] TIMEOUT      = 32'hC000,
   parameter int          RST_CYC      = 3,
   parameter int          PULSE_CYC    = 1,
   parameter logic [31:0] SEED         = 32'h1
) (
   input  logic                  clk,
   input  logic                  rstn,
   fault_campaign_ctrl_if.master bus
);
   localparam int TGT_W = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [31:0] SPAN_MASK =
      (32'd1 << DELAY_SPAN_W) - 32'd1;
   localparam logic [31:0] POLY = 32'h8020_0003;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_WAIT_BEGIN,
      S_ARM,
      S_INJECT,
      S_WAIT_DONE,
      S_RECORD,
      S_DONE
   } state_t;

   state_t            state;
   logic [31:0]       r;
   logic              start_q;
   logic [31:0]       rcnt;
   logic [31:0]       dcnt;
   logic [31:0]       pcnt;
   logic [31:0]       tcnt;
   logic [31:0]       delay_q;
   logic              inj_q;
   logic              fired_q;

   logic              dut_rstn_q;
   logic              fv_q;
   logic [1:0]        op_q;
   logic [TGT_W-1:0]  tgt_q;
   logic [DATA_W-1:0] mask_q;
   logic              rv_q;
   logic [1:0]        rc_q;
   logic [15:0]       exp_q;
   logic [15:0]       inj_cnt_q;
   logic [15:0]       dinj_q;
   logic [15:0]       to_q;
   logic              busy_q;
   logic              cdone_q;

   logic              draw_inj;
   logic [TGT_W-1:0]  draw_tgt;
   logic [BIT_W-1:0]  draw_bit;
   logic [31:0]       draw_delay;
   logic [DATA_W-1:0] draw_mask;
   logic              go;
   logic              in_run;
   logic              timeout_hit;
   logic              end_now;
   logic [1:0]        end_code;
   logic              last_exp;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign draw_inj = (32'(r[7:0]) < 32'(FR_THRESH))
                   && (bus.fault_mode != 2'd0);
   assign draw_tgt = TGT_W'(
      (32'(r[15:8]) * 32'(N_TARGETS)) >> 8);
   assign draw_bit   = r[16 +: BIT_W];
   assign draw_delay = 32'(DELAY_MIN)
                     + (32'(r[31:21]) & SPAN_MASK);

   // Mask shape follows the fault flavour being armed.
   always_comb begin
      draw_mask = '0;
      unique case (1'b1)
         (bus.fault_mode == 2'd1): draw_mask = '1;
         (bus.fault_mode == 2'd2):
            draw_mask = DATA_W'(1) << draw_bit;
         default: draw_mask = '0;
      endcase
   end

   assign go = (state == S_IDLE && bus.start)
            || (state == S_DONE && bus.start && !start_q);
   assign in_run = (state == S_ARM) || (state == S_INJECT)
                || (state == S_WAIT_DONE);
   assign timeout_hit = (tcnt == TIMEOUT);
   assign end_now  = in_run && (bus.run_done || timeout_hit);
   assign end_code = bus.run_done ? {1'b0, fired_q} : 2'd2;
   assign last_exp = (32'(exp_q) + 32'd1) == 32'(NEXP);

   // Galois LFSR free-runs so draws depend on run_begin timing.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r <= SEED;
      end else begin
         r <= (r >> 1) ^ (r[0] ? POLY : 32'h0);
      end
   end

   // Campaign sequencer with all outputs registered.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= S_IDLE;
         start_q    <= 1'b0;
         rcnt       <= '0;
         dcnt       <= '0;
         pcnt       <= '0;
         tcnt       <= '0;
         delay_q    <= '0;
         inj_q      <= 1'b0;
         fired_q    <= 1'b0;
         dut_rstn_q <= 1'b0;
         fv_q       <= 1'b0;
         op_q       <= 2'd0;
         tgt_q      <= '0;
         mask_q     <= '0;
         rv_q       <= 1'b0;
         rc_q       <= 2'd0;
         exp_q      <= '0;
         inj_cnt_q  <= '0;
         dinj_q     <= '0;
         to_q       <= '0;
         busy_q     <= 1'b0;
         cdone_q    <= 1'b0;
      end else begin
         start_q <= bus.start;
         rv_q    <= 1'b0;
         tcnt    <= tcnt + 32'd1;
         if (go) begin
            exp_q      <= '0;
            inj_cnt_q  <= '0;
            dinj_q     <= '0;
            to_q       <= '0;
            busy_q     <= 1'b1;
            cdone_q    <= 1'b0;
            dut_rstn_q <= 1'b0;
            rcnt       <= '0;
            state      <= S_RST;
         end else if (end_now) begin
            rv_q  <= 1'b1;
            rc_q  <= end_code;
            fv_q  <= 1'b0;
            state <= S_RECORD;
         end else begin
            unique case (state)
               S_IDLE: begin
                  dut_rstn_q <= 1'b1;
               end
               S_RST: begin
                  if (rcnt == 32'(RST_CYC) - 32'd1) begin
                     dut_rstn_q <= 1'b1;
                     state      <= S_WAIT_BEGIN;
                  end else begin
                     rcnt <= rcnt + 32'd1;
                  end
               end
               S_WAIT_BEGIN: begin
                  if (bus.run_begin) begin
                     inj_q   <= draw_inj;
                     fired_q <= 1'b0;
                     op_q    <= bus.fault_mode;
                     tgt_q   <= draw_tgt;
                     mask_q  <= draw_mask;
                     delay_q <= draw_delay;
                     dcnt    <= '0;
                     tcnt    <= '0;
                     if (draw_inj) begin
                        inj_cnt_q <= sat_inc(inj_cnt_q);
                     end
                     state <= S_ARM;
                  end
               end
               S_ARM: begin
                  if (dcnt == delay_q - 32'd1) begin
                     if (inj_q) begin
                        fv_q    <= 1'b1;
                        fired_q <= 1'b1;
                        pcnt    <= '0;
                        state   <= S_INJECT;
                     end else begin
                        state <= S_WAIT_DONE;
                     end
                  end else begin
                     dcnt <= dcnt + 32'd1;
                  end
               end
               S_INJECT: begin
                  if (pcnt == 32'(PULSE_CYC) - 32'd1) begin
                     fv_q  <= 1'b0;
                     state <= S_WAIT_DONE;
                  end else begin
                     pcnt <= pcnt + 32'd1;
                  end
               end
               S_WAIT_DONE: begin
                  state <= S_WAIT_DONE;
               end
               S_RECORD: begin
                  exp_q <= sat_inc(exp_q);
                  if (rc_q == 2'd1) begin
                     dinj_q <= sat_inc(dinj_q);
                  end
                  if (rc_q == 2'd2) begin
                     to_q <= sat_inc(to_q);
                  end
                  if (last_exp) begin
                     busy_q  <= 1'b0;
                     cdone_q <= 1'b1;
                     state   <= S_DONE;
                  end else begin
                     dut_rstn_q <= 1'b0;
                     rcnt       <= '0;
                     state      <= S_RST;
                  end
               end
               S_DONE: begin
                  state <= S_DONE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.dut_rstn      = dut_rstn_q;
   assign bus.fault_valid   = fv_q;
   assign bus.fault_op      = op_q;
   assign bus.fault_target  = tgt_q;
   assign bus.fault_mask    = mask_q;
   assign bus.result_valid  = rv_q;
   assign bus.result_code   = rc_q;
   assign bus.exp_count     = exp_q;
   assign bus.cnt_inj       = inj_cnt_q;
   assign bus.cnt_done_inj  = dinj_q;
   assign bus.cnt_timeout   = to_q;
   assign bus.busy          = busy_q;
   assign bus.campaign_done = cdone_q;
endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Bench for fault_campaign_ctrl: a stub CPU plus an experiment-level
// outcome model driven by randomized start/done timing.
module tb_fault_campaign_ctrl;
   localparam int NT    = 7;
   localparam int DW    = 32;
   localparam int TW    = $clog2(NT);
   localparam int NEXP  = 4;
   localparam int FR    = 179;
   localparam int DMIN  = 40;
   localparam int SPANW = 5;
   localparam int TO_I  = 256;
   localparam int RSTC  = 3;
   localparam int PULSE = 2;
   localparam logic [31:0] SEED = 32'h1;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   nvec = 0;
   int   nfail = 0;
   logic [31:0] m_r;

   fault_campaign_ctrl_if #(.N_TARGETS(NT), .DATA_W(DW)) bus();

   fault_campaign_ctrl #(
      .N_TARGETS(NT), .DATA_W(DW), .NEXP(NEXP),
      .FR_THRESH(FR), .DELAY_MIN(DMIN),
      .DELAY_SPAN_W(SPANW), .TIMEOUT(32'(TO_I)),
      .RST_CYC(RSTC), .PULSE_CYC(PULSE), .SEED(SEED)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference random stream: the documented Galois recurrence.
   always @(posedge clk) begin
      if (!rstn) m_r <= SEED;
      else m_r <= (m_r >> 1) ^ (m_r[0] ? 32'h80200003 : 32'h0);
   end

   task automatic test_reset();
      bus.start = 0; bus.fault_mode = 0;
      bus.run_begin = 0; bus.run_done = 0;
      rstn = 0;
      repeat (3) @(negedge clk);
      nvec++;
      if (bus.dut_rstn !== 0 || bus.fault_valid !== 0
          || bus.fault_op !== 0 || bus.fault_target !== 0
          || bus.fault_mask !== 0 || bus.result_valid !== 0
          || bus.result_code !== 0 || bus.exp_count !== 0
          || bus.cnt_inj !== 0 || bus.cnt_done_inj !== 0
          || bus.cnt_timeout !== 0 || bus.busy !== 0
          || bus.campaign_done !== 0) begin
         nfail++;
         $display("FAIL reset_state got rstn=%b fv=%b busy=%b cd=%b exp=%0d",
            bus.dut_rstn, bus.fault_valid, bus.busy,
            bus.campaign_done, bus.exp_count);
      end
      rstn = 1;
      @(negedge clk);
      nvec++;
      if (bus.dut_rstn !== 1 || bus.busy !== 0) begin
         nfail++;
         $display("FAIL idle_release got dut_rstn=%b busy=%b want 1 0",
            bus.dut_rstn, bus.busy);
      end
   endtask

   // policy: 0 mixed, 1 complete after fault, 2 never done,
   // 3 done inside delay, 4 done on the timeout cycle
   task automatic run_campaign(input int policy, input bit allow_zero);
      int m_exp, m_inj, m_dinj, m_to;
      m_exp = 0; m_inj = 0; m_dinj = 0; m_to = 0;
      bus.start = 1;
      @(negedge clk);
      bus.start = 0;
      nvec++;
      if (bus.busy !== 1 || bus.campaign_done !== 0
          || bus.exp_count !== 0 || bus.cnt_inj !== 0
          || bus.cnt_done_inj !== 0 || bus.cnt_timeout !== 0) begin
         nfail++;
         $display("FAIL start_clear got busy=%b cd=%b exp=%0d inj=%0d",
            bus.busy, bus.campaign_done, bus.exp_count, bus.cnt_inj);
      end
      for (int e = 0; e < NEXP; e++) begin
         int lowc, d, en, code, dly, tgt, bitn;
         logic [31:0] cur, mask_e;
         logic [1:0] mode;
         bit inj, fv_e, rv_e;
         lowc = 0;
         while (bus.dut_rstn !== 1'b1 && lowc < 50) begin
            lowc++;
            @(negedge clk);
         end
         nvec++;
         if (lowc != RSTC) begin
            nfail++;
            $display("FAIL rst_cycles exp%0d got %0d want %0d",
               e, lowc, RSTC);
         end
         repeat ($urandom_range(0, 6)) @(negedge clk);
         mode = allow_zero ? 2'($urandom_range(0, 3))
                           : 2'($urandom_range(1, 3));
         bus.fault_mode = mode;
         bus.run_begin = 1;
         cur = m_r;
         inj = (int'(cur[7:0]) < FR) && (mode != 0);
         tgt = (int'(cur[15:8]) * NT) / 256;
         bitn = int'(cur[20:16]);
         dly = DMIN + (int'(cur[31:21]) % (1 << SPANW));
         mask_e = (mode == 1) ? 32'hFFFF_FFFF
                : (mode == 2) ? (32'h1 << bitn) : 32'h0;
         case (policy)
            1: d = dly + PULSE + $urandom_range(1, 40);
            2: d = 1 << 30;
            3: d = dly - 10;
            4: d = TO_I + 1;
            default: d = ($urandom_range(0, 3) == 0) ? (1 << 30)
                       : $urandom_range(1, TO_I + 10);
         endcase
         en = (d <= TO_I + 1) ? d : TO_I + 1;
         if (d > TO_I + 1) code = 2;
         else code = (inj && dly + 1 <= d) ? 1 : 0;
         for (int k = 1; k <= en + 1; k++) begin
            @(negedge clk);
            if (k == 1) bus.fault_mode = 2'($urandom);
            fv_e = inj && k >= dly + 1 && k <= dly + PULSE
                && k <= en;
            nvec++;
            if (bus.fault_valid !== fv_e) begin
               nfail++;
               $display("FAIL fault_valid exp%0d k=%0d got %b want %b",
                  e, k, bus.fault_valid, fv_e);
            end
            if (fv_e) begin
               nvec++;
               if (bus.fault_op !== mode
                   || bus.fault_target !== TW'(tgt)
                   || bus.fault_mask !== mask_e) begin
                  nfail++;
                  $display("FAIL fault_fields exp%0d got op=%0d t=%0d m=%h want %0d %0d %h",
                     e, bus.fault_op, bus.fault_target,
                     bus.fault_mask, mode, tgt, mask_e);
               end
            end
            rv_e = (k == en + 1);
            nvec++;
            if (bus.result_valid !== rv_e) begin
               nfail++;
               $display("FAIL result_valid exp%0d k=%0d got %b want %b",
                  e, k, bus.result_valid, rv_e);
            end
            if (rv_e) begin
               nvec++;
               if (bus.result_code !== 2'(code)) begin
                  nfail++;
                  $display("FAIL result_code exp%0d got %0d want %0d",
                     e, bus.result_code, code);
               end
            end
            if (k == d) bus.run_done = 1;
         end
         bus.run_begin = 0;
         bus.run_done = 0;
         m_exp++;
         if (inj) m_inj++;
         if (code == 1) m_dinj++;
         if (code == 2) m_to++;
         @(negedge clk);
         nvec++;
         if ({bus.exp_count, bus.cnt_inj, bus.cnt_done_inj,
              bus.cnt_timeout} !== {16'(m_exp), 16'(m_inj),
              16'(m_dinj), 16'(m_to)}) begin
            nfail++;
            $display("FAIL counters exp%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               e, bus.exp_count, bus.cnt_inj, bus.cnt_done_inj,
               bus.cnt_timeout, m_exp, m_inj, m_dinj, m_to);
         end
         if (e == NEXP - 1) begin
            nvec++;
            if (bus.campaign_done !== 1 || bus.busy !== 0) begin
               nfail++;
               $display("FAIL campaign_done got cd=%b busy=%b want 1 0",
                  bus.campaign_done, bus.busy);
            end
         end
      end
   endtask

   task automatic test_normal();
      run_campaign(1, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_campaign(0, 1'b1);
   endtask

   task automatic test_timeout();
      run_campaign(2, 1'b1);
   endtask

   task automatic test_early_done();
      run_campaign(3, 1'b0);
   endtask

   task automatic test_done_timeout_tie();
      run_campaign(4, 1'b0);
   endtask

   task automatic test_reset_in_inject();
      bit found;
      int cyc;
      found = 0;
      cyc = 0;
      bus.fault_mode = 2;
      bus.start = 1;
      while (!found && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (bus.fault_valid === 1'b1) begin
            found = 1;
         end else begin
            bus.start = bus.campaign_done && !bus.start;
            bus.run_begin = bus.dut_rstn && bus.busy;
         end
      end
      nvec++;
      if (!found) begin
         nfail++;
         $display("FAIL inject_reach got no fault_valid in %0d cycles",
            cyc);
      end
      rstn = 0;
      bus.start = 0;
      bus.run_begin = 0;
      @(negedge clk);
      nvec++;
      if (bus.fault_valid !== 0 || bus.busy !== 0
          || bus.dut_rstn !== 0 || bus.cnt_inj !== 0
          || bus.exp_count !== 0) begin
         nfail++;
         $display("FAIL reset_in_inject got fv=%b busy=%b rstn=%b inj=%0d",
            bus.fault_valid, bus.busy, bus.dut_rstn, bus.cnt_inj);
      end
      rstn = 1;
      @(negedge clk);
      nvec++;
      if (bus.dut_rstn !== 1 || bus.busy !== 0
          || bus.campaign_done !== 0) begin
         nfail++;
         $display("FAIL idle_after_reset got rstn=%b busy=%b cd=%b",
            bus.dut_rstn, bus.busy, bus.campaign_done);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_back_to_back();
      test_timeout();
      test_early_done();
      test_done_timeout_tie();
      test_reset_in_inject();
      run_campaign(0, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==",
         nvec, nfail);
      $finish;
   end
endmodule
